// File: rtl/idma_wr_sync_top.sv
// rtl/idma_wr_sync_top.sv - AXI4 write-master DMA engine: job split into INCR bursts, AW/W/B handling, done pulse
// Optional: `define IDMA_WR_BRESP_ERR_EN to record B error responses on wr_err.
module idma_wr_sync_top #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IDW    = 8,
  parameter int AXI_LENW   = 8,
  parameter int STRBW      = AXI_DW / 8,
  parameter int MAX_BURST  = 16,
  parameter int OUTSTD_MAX = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                wr_req,
  input  logic [AXI_AW-1:0]   wr_addr,
  input  logic [31:0]         wr_num,
  output logic                wr_addr_ready,
  input  logic [3:0]          wr_cfg_outstd,
  input  logic                wr_data_valid,
  input  logic [AXI_DW-1:0]   wr_data,
  input  logic [STRBW-1:0]    wr_strb,
  output logic                wr_data_ready,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [AXI_IDW-1:0]  m_awid,
  output logic [AXI_AW-1:0]   m_awaddr,
  output logic [AXI_LENW-1:0] m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [AXI_DW-1:0]   m_wdata,
  output logic [STRBW-1:0]    m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  input  logic [AXI_IDW-1:0]  m_bid,
  input  logic [1:0]          m_bresp,
  output logic                m_bready,
  output logic                wr_busy,
  output logic                wr_done_intr,
  output logic                wr_err
);

  localparam int SZ  = $clog2(STRBW);
  localparam int OCW = $clog2(OUTSTD_MAX + 1);
  localparam int PW  = (OUTSTD_MAX > 1) ? $clog2(OUTSTD_MAX) : 1;
  localparam logic [AXI_AW-1:0] ALIGN_MASK = AXI_AW'(STRBW - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [AXI_AW-1:0]    addr;
  logic [31:0]          rem;
  logic [OCW-1:0]       outstd;
  logic [OCW-1:0]       limit;
  logic                 aw_hold;

  logic [AXI_LENW-1:0]  fifo_mem [OUTSTD_MAX];
  logic [PW-1:0]        wptr, rptr;
  logic [OCW-1:0]       fifo_cnt;
  logic                 fifo_full, fifo_ne;
  logic [AXI_LENW-1:0]  beat_cnt;

  logic [12:0]          bytes_to_4k;
  logic [31:0]          beats_to_4k, burst_len;
  logic                 job_accept, aw_fire, b_fire, w_fire, w_pop;

  always_comb begin
    bytes_to_4k = 13'h1000 - {1'b0, addr[11:0]};
    beats_to_4k = 32'(bytes_to_4k) >> SZ;
    burst_len   = rem;
    if (burst_len > 32'(MAX_BURST)) burst_len = 32'(MAX_BURST);
    if (burst_len > beats_to_4k)    burst_len = beats_to_4k;
  end

  always_comb begin
    limit = OCW'(1);
    if (wr_cfg_outstd == 4'd0)                    limit = OCW'(1);
    else if (32'(wr_cfg_outstd) > 32'(OUTSTD_MAX)) limit = OCW'(OUTSTD_MAX);
    else                                           limit = OCW'(wr_cfg_outstd);
  end

  assign fifo_full = (fifo_cnt == OCW'(OUTSTD_MAX));
  assign fifo_ne   = (fifo_cnt != '0);

  // Once offered, AW stays valid until accepted even if the limit is lowered meanwhile.
  assign m_awvalid  = (state == ISSUE) && (rem != 32'd0) &&
                      (aw_hold || ((outstd < limit) && !fifo_full));
  assign aw_fire    = m_awvalid & m_awready;
  assign b_fire     = m_bvalid && (outstd != '0);
  assign job_accept = (state == IDLE) && wr_req;

  assign m_awid    = '0;
  assign m_awaddr  = addr;
  assign m_awlen   = AXI_LENW'(burst_len - 32'd1);
  assign m_awsize  = 3'(SZ);
  assign m_awburst = 2'b01;
  assign m_bready  = 1'b1;

  assign m_wvalid      = wr_data_valid & fifo_ne;
  assign wr_data_ready = m_wready & fifo_ne;
  assign m_wdata       = wr_data;
  assign m_wstrb       = wr_strb;
  assign m_wlast       = fifo_ne && (beat_cnt == fifo_mem[rptr]);
  assign w_fire        = m_wvalid & m_wready;
  assign w_pop         = w_fire & m_wlast;

  assign wr_addr_ready = (state == IDLE);
  assign wr_busy       = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    wr_done_intr = 1'b0;
    case (state)
      IDLE:  if (wr_req) state_nxt = (wr_num == 32'd0) ? DRAIN : ISSUE;
      ISSUE: if ((rem == 32'd0) || (aw_fire && (burst_len == rem))) state_nxt = DRAIN;
      DRAIN: if (!fifo_ne && (outstd == '0)) begin
        wr_done_intr = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      outstd  <= '0;
      aw_hold <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_hold <= m_awvalid & ~m_awready;
      if (job_accept) begin
        addr <= wr_addr & ~ALIGN_MASK;
        rem  <= wr_num;
      end else if (aw_fire) begin
        addr <= addr + (AXI_AW'(burst_len) << SZ);
        rem  <= rem - burst_len;
      end
      case ({aw_fire, b_fire})
        2'b10:   outstd <= outstd + OCW'(1);
        2'b01:   outstd <= outstd - OCW'(1);
        default: outstd <= outstd;
      endcase
    end
  end

  // Burst-length FIFO holds len-1 so the head compares directly with the beat counter.
  always_ff @(posedge aclk) begin
    if (aw_fire) fifo_mem[wptr] <= AXI_LENW'(burst_len - 32'd1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (aw_fire) wptr <= (wptr == PW'(OUTSTD_MAX - 1)) ? '0 : wptr + PW'(1);
      if (w_pop)   rptr <= (rptr == PW'(OUTSTD_MAX - 1)) ? '0 : rptr + PW'(1);
      case ({aw_fire, w_pop})
        2'b10:   fifo_cnt <= fifo_cnt + OCW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (w_fire) beat_cnt <= m_wlast ? '0 : beat_cnt + AXI_LENW'(1);
    end
  end

`ifdef IDMA_WR_BRESP_ERR_EN
  logic err_q;
  logic unused_b;
  assign unused_b = ^{m_bid, m_bresp[0]};

  always_ff @(posedge aclk) begin
    if (areset)                       err_q <= 1'b0;
    else if (job_accept)              err_q <= 1'b0;
    else if (m_bvalid && m_bresp[1])  err_q <= 1'b1;
  end
  assign wr_err = err_q;
`else
  logic unused_b;
  assign unused_b = ^{m_bid, m_bresp};
  assign wr_err   = 1'b0;
`endif

endmodule
